tdm_demux_rx: RTL and testbench

Two-channel time-division demultiplexer: the receive end of a 2-to-1 mux link whose select alternates every bit slot. It accepts a serial stream with a frame-sync marker, steers even slots to channel A and odd slots to channel B, assembles one W-bit word per channel, and presents both words on a single-entry valid/ready output. It sits between the serial link pins and the word-level consumer logic.

---
 rtl/tdm_pkg.sv | 11 +
 rtl/tdm_shift_reg.sv | 34 +++
 rtl/tdm_demux_rx.sv | 137 +++++++++++++
 tb/tb_tdm_demux_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the two-channel TDM receive demultiplexer.
package tdm_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_shift_reg.sv
// W-bit MSB-first shift register; exposes the value it will hold after this
// edge so the frame's final bit can be captured in the same cycle it arrives.
module tdm_shift_reg
  import tdm_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q_next_c
);

  logic [W-1:0] q;

  // Shift left by one, new bit enters at the LSB end.
  always_comb begin
    q_next_c = q;
    if (en) begin
      q_next_c = {q[W-2:0], d};
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next_c;
    end
  end

endmodule

// File: rtl/tdm_demux_rx.sv
// Two-channel TDM receiver: even slots to A, odd slots to B, one frame of
// 2*W slots delivered through a single-entry valid/ready output register.
module tdm_demux_rx
  import tdm_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] a_word,
  output logic [W-1:0] b_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sel_out,
  output logic         frame_err,
  output logic         overflow
);

  localparam int unsigned   CW   = $clog2(2 * W);
  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_en, b_en;
  logic          complete;
  logic          err_d;
  logic          sel_d;
  logic [W-1:0]  a_nxt, b_nxt;
  logic          load, ovf_d, valid_d;

  tdm_shift_reg #(.W(W)) u_shift_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (a_en),
    .d        (din),
    .q_next_c (a_nxt)
  );

  tdm_shift_reg #(.W(W)) u_shift_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (b_en),
    .d        (din),
    .q_next_c (b_nxt)
  );

  // Frame FSM: slot steering, resync detection and frame completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_en     = 1'b0;
    b_en     = 1'b0;
    complete = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (din_valid && frame_sync) begin
          a_en    = 1'b1;
          cnt_d   = CW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (din_valid) begin
          if (frame_sync) begin
            // Sync restarts the frame; mid-frame it also flags the lost partial.
            err_d = (cnt_q != '0);
            a_en  = 1'b1;
            cnt_d = CW'(1);
          end else if (cnt_q == '0) begin
            // Data where a sync was due: lost alignment, drop the bit.
            state_d = HUNT;
          end else begin
            a_en = ~cnt_q[0];
            b_en = cnt_q[0];
            if (cnt_q == LAST) begin
              complete = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
    sel_d = (state_d == RECV) ? cnt_d[0] : 1'b0;
  end

  // FSM state, slot counter and slot indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      sel_out   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_out   <= sel_d;
      frame_err <= err_d;
    end
  end

  // Output register control: load when free or draining, otherwise drop.
  always_comb begin
    load    = complete && (!out_valid || out_ready);
    ovf_d   = complete && out_valid && !out_ready;
    valid_d = out_valid;
    if (load) begin
      valid_d = 1'b1;
    end else if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Held frame and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_word    <= '0;
      b_word    <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= valid_d;
      overflow  <= ovf_d;
      if (load) begin
        a_word <= a_nxt;
        b_word <= b_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Scoreboard bench for tdm_demux_rx: stimulus pushes expected frames, a
// negedge monitor compares every presented frame and counts flag pulses.
module tb_tdm_demux_rx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] a_word;
  logic [W-1:0] b_word;
  logic         out_valid;
  logic         out_ready;
  logic         sel_out;
  logic         frame_err;
  logic         overflow;

  int vectors;
  int miscompares;
  int err_seen;
  int ovf_seen;
  int exp_err;
  int exp_ovf;
  logic [2*W-1:0] exp_q[$];

  tdm_demux_rx #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .a_word     (a_word),
    .b_word     (b_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel_out    (sel_out),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the presented frame with the scoreboard head every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (overflow) ovf_seen++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {a_word, b_word}, 32'hdead);
        end else begin
          chk("frame_words", {a_word, b_word}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_bit(input logic d, input logic sync);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = sync;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic send_partial(input int n);
    for (int k = 0; k < n; k++) send_bit(1'($urandom_range(0, 1)), k == 0);
  endtask

  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit gaps, input bit push);
    logic bitv;
    for (int k = 0; k < 2 * W; k++) begin
      if (k > 0) chk("sel_out", sel_out, 32'(k % 2));
      if (gaps && (k == 3 || k == 10)) begin
        din_valid  = 1'b0;
        frame_sync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        frame_sync = 1'b0;
        chk("sel_out_gap", sel_out, 32'(k % 2));
      end
      bitv = (k % 2 == 0) ? a[W-1-k/2] : b[W-1-k/2];
      if (k == 2 * W - 1 && push) exp_q.push_back({a, b});
      send_bit(bitv, k == 0);
    end
    chk("latency_valid", out_valid, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, a_word, 0);
    chk({tag, "_b"}, b_word, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_sel"}, sel_out, 0);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    err_seen = 0; ovf_seen = 0; exp_err = 0; exp_ovf = 0;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; out_ready = 1'b0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      din = ~din; din_valid = ~din_valid; frame_sync = 1'(i % 2); out_ready = ~out_ready;
    end
    #1;
    chk_all_zero("reset");
    din_valid = 1'b0; frame_sync = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // HUNT ignores data without sync.
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("hunt_sel", sel_out, 0);

    // Single frame.
    send_frame(8'hA5, 8'h3C, 1'b0, 1'b1);

    // Unsynced bit at slot 0 returns to HUNT quietly; following junk ignored.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("rehunt_sel", sel_out, 0);

    // Back-to-back frames with idle gaps.
    send_frame(8'h01, 8'hFF, 1'b1, 1'b1);
    send_frame(8'h80, 8'h00, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("err_pulses_clean", err_seen, exp_err);

    // Sync at slot 5 aborts the partial frame.
    send_partial(5);
    exp_err++;
    send_frame(8'h96, 8'h69, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("err_pulses_resync", err_seen, exp_err);

    // Consumer stalled across two completions.
    out_ready = 1'b0;
    send_frame(8'h11, 8'h22, 1'b0, 1'b1);
    exp_ovf++;
    send_frame(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_pulses", ovf_seen, exp_ovf);
    chk("stall_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_valid", out_valid, 0);
    chk("drain_a_hold", a_word, 8'h11);

    // Reset mid-frame with a frame held.
    out_ready = 1'b0;
    send_frame(8'h55, 8'h66, 1'b0, 1'b1);
    send_partial(9);
    chk("pre_reset_sel", sel_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_bit(1'b0, 1'b0);
    send_frame(8'hC3, 8'h5A, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("err_pulses_final", err_seen, exp_err);
    chk("ovf_pulses_final", ovf_seen, exp_ovf);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
